// File: rtl/rr_resource_arbiter_pkg.sv
// rtl/rr_resource_arbiter_pkg.sv - shared types and helpers for the round-robin resource arbiter
package rr_resource_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n == 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_resource_arbiter_if.sv
// rtl/rr_resource_arbiter_if.sv - request/grant/resource handshake bundle for the arbiter
interface rr_resource_arbiter_if
    import rr_resource_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4
);
    localparam int ID_W = id_width(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0] request;
    logic                      ack;
    logic                      done;
    logic                      grant_valid;
    logic [NUM_REQUESTERS-1:0] grant_onehot;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        output request, ack, done,
        input  grant_valid, grant_onehot, grant_id, busy
    );

    modport slave (
        input  request, ack, done,
        output grant_valid, grant_onehot, grant_id, busy
    );

endinterface

// File: rtl/one_hot_to_integer.sv
// rtl/one_hot_to_integer.sv - encodes a one-hot (or all-zero) vector into its bit index
module one_hot_to_integer
    import rr_resource_arbiter_pkg::*;
#(
    parameter  int C_WIDTH = 4,
    localparam int ID_W    = id_width(C_WIDTH)
) (
    input  logic [C_WIDTH-1:0] onehot_i,
    output logic [ID_W-1:0]    id_o
);

    // OR of set-bit indices; all-zero input encodes to 0
    always_comb begin
        id_o = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (onehot_i[i]) begin
                id_o = id_o | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// rtl/rr_resource_arbiter.sv - round-robin arbiter sharing one multi-cycle resource
module rr_resource_arbiter
    import rr_resource_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_resource_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQUESTERS);

    arb_state_e                state_q;
    logic [ID_W-1:0]           last_winner_q;
    logic                      grant_valid_q;
    logic [NUM_REQUESTERS-1:0] grant_onehot_q;
    logic [ID_W-1:0]           grant_id_q;
    logic                      busy_q;

    logic [NUM_REQUESTERS-1:0] prio_mask;
    logic [NUM_REQUESTERS-1:0] masked_req;
    logic [NUM_REQUESTERS-1:0] pick_src;
    logic [NUM_REQUESTERS-1:0] win_onehot_d;
    logic [ID_W-1:0]           win_id_d;

    // Requesters above the last winner take precedence; if none, fall back to the lowest index
    always_comb begin
        prio_mask = '0;
        for (int j = 0; j < NUM_REQUESTERS; j++) begin
            prio_mask[j] = (ID_W'(j) > last_winner_q);
        end
        masked_req   = bus.request & prio_mask;
        pick_src     = (|masked_req) ? masked_req : bus.request;
        win_onehot_d = pick_src & (~pick_src + NUM_REQUESTERS'(1));
    end

    one_hot_to_integer #(
        .C_WIDTH(NUM_REQUESTERS)
    ) u_encode (
        .onehot_i(win_onehot_d),
        .id_o    (win_id_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_winner_q  <= ID_W'(NUM_REQUESTERS - 1);
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_id_q     <= '0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|bus.request) begin
                        grant_valid_q  <= 1'b1;
                        grant_onehot_q <= win_onehot_d;
                        grant_id_q     <= win_id_d;
                        state_q        <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        last_winner_q  <= grant_id_q;
                        grant_valid_q  <= 1'b0;
                        grant_onehot_q <= '0;
                        grant_id_q     <= '0;
                        // A resource finishing in its accept cycle never shows as busy
                        if (bus.done) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.busy         = busy_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_onehot_q))
                else $error("grant_onehot has more than one bit set: %b", grant_onehot_q);
            assert (grant_valid_q == (|grant_onehot_q))
                else $error("grant_valid disagrees with grant_onehot");
            assert (!(grant_valid_q && busy_q))
                else $error("grant_valid and busy both high");
        end
    end
`endif

endmodule
